// File: rtl/lsu32_pkg.sv
// lsu32_pkg: FSM state encoding and access-size codes shared by the LSU32 load/store unit.
package lsu32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

endpackage

// File: rtl/lsu32_if.sv
// lsu32_if: CPU request/response and data-memory signals of the LSU32; slave = LSU side, master = CPU/memory side.
interface lsu32_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req, we, size, uns, addr, wdata, mem_rdata,
        output busy, ready, rdata, err, mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output req, we, size, uns, addr, wdata, mem_rdata,
        input  busy, ready, rdata, err, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/lsu32_align.sv
// lsu32_align: combinational big-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu32_align
    import lsu32_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_store
);
    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 is the most significant lane, so the shift is (3 - off) bytes / (1 - off[1]) halves.
    assign w_bsh  = {~i_off, 3'b000};
    assign w_hsh  = {~i_off[1], 4'b0000};
    assign w_byte = i_rword[w_bsh +: 8];
    assign w_half = i_rword[w_hsh +: 16];

    always_comb begin
        o_load  = i_rword;
        o_store = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load  = i_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
                o_store = (i_old & ~(32'h0000_00FF << w_bsh)) | ({24'd0, i_wdata[7:0]} << w_bsh);
            end
            SZ_HALF: begin
                o_load  = i_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                o_store = (i_old & ~(32'h0000_FFFF << w_hsh)) | ({16'd0, i_wdata[15:0]} << w_hsh);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu32.sv
// lsu32: FSM-sequenced load/store unit in front of a 32-word data memory selected by addr[31:7].
// Define LSU32_SUBWORD_EN for byte/half accesses (read-modify-write stores); otherwise only aligned words are legal.
module lsu32
    import lsu32_pkg::*;
#(
    parameter logic [24:0] BASE_ADDRESS = 25'd0
) (
    input  logic   clk,
    input  logic   reset_n,
    lsu32_if.slave bus
);
    lsu_state_t  r_state;
    lsu_state_t  w_state_next;
    logic        r_we;
    logic        r_err;
    logic [29:0] r_waddr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        w_align_err;
    logic        w_err;
    logic [31:0] w_load;
    logic [31:0] w_store;
`ifdef LSU32_SUBWORD_EN
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_uns;
    logic [31:0] r_word;
`endif

    always_comb begin
`ifdef LSU32_SUBWORD_EN
        case (bus.size)
            SZ_BYTE: w_align_err = 1'b0;
            SZ_HALF: w_align_err = bus.addr[0];
            SZ_WORD: w_align_err = (bus.addr[1:0] != 2'b00);
            default: w_align_err = 1'b1;
        endcase
`else
        w_align_err = (bus.size != SZ_WORD) || (bus.addr[1:0] != 2'b00);
`endif
        w_err = w_align_err || (bus.addr[31:7] != BASE_ADDRESS);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    if (w_err)
                        w_state_next = ST_DONE;
                    else if (!bus.we)
                        w_state_next = ST_READ;
`ifdef LSU32_SUBWORD_EN
                    else if (bus.size != SZ_WORD)
                        w_state_next = ST_READ;
`endif
                    else
                        w_state_next = ST_WRITE;
                end
            end
            // A store passing through READ is a read-modify-write.
            ST_READ:  w_state_next = r_we ? ST_WRITE : ST_DONE;
            ST_WRITE: w_state_next = ST_DONE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
`ifdef LSU32_SUBWORD_EN
            r_size  <= SZ_BYTE;
            r_off   <= 2'b00;
            r_uns   <= 1'b0;
            r_word  <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_err   <= w_err;
                        r_waddr <= bus.addr[31:2];
                        r_wdata <= bus.wdata;
                        r_rdata <= '0;
`ifdef LSU32_SUBWORD_EN
                        r_size  <= bus.size;
                        r_off   <= bus.addr[1:0];
                        r_uns   <= bus.uns;
`endif
                    end
                end
                ST_READ: begin
                    if (!r_we)
                        r_rdata <= w_load;
`ifdef LSU32_SUBWORD_EN
                    else
                        r_word  <= bus.mem_rdata;
`endif
                end
                default: ;
            endcase
        end
    end

`ifdef LSU32_SUBWORD_EN
    lsu32_align u_align (
        .i_size  (r_size),
        .i_uns   (r_uns),
        .i_off   (r_off),
        .i_rword (bus.mem_rdata),
        .i_old   (r_word),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_store (w_store)
    );
`else
    assign w_load  = bus.mem_rdata;
    assign w_store = r_wdata;
`endif

    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.ready       = (r_state == ST_DONE);
    assign bus.mem_read    = (r_state == ST_READ);
    assign bus.mem_write   = (r_state == ST_WRITE);
    assign bus.mem_address = {r_waddr, 2'b00};
    assign bus.mem_wdata   = w_store;
    assign bus.rdata       = r_rdata;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_lsu32.sv
// tb_lsu32: randomized and directed checks of lsu32 against a byte-addressed big-endian memory model.
module tb_lsu32;
    logic clk;
    logic reset_n;
    logic preload;
    int   n_cmp;
    int   n_bad;

    lsu32_if bus();

    lsu32 #(.BASE_ADDRESS(25'd0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory seen by the DUT, plus the independent reference image as bytes (address order = significance order).
    logic [31:0] dmem [0:31];
    logic [31:0] pre  [0:31];
    logic [7:0]  ref_mem [0:127];

    assign bus.mem_rdata = dmem[bus.mem_address[6:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) dmem[i] <= pre[i];
        end else if (bus.mem_write) begin
            dmem[bus.mem_address[6:2]] <= bus.mem_wdata;
        end
    end

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        bit          er;
        int          lat;
        bit          ck;
        logic [31:0] word;
    } dvec_t;

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[4*idx], ref_mem[4*idx+1], ref_mem[4*idx+2], ref_mem[4*idx+3]};
    endfunction

    function automatic void ref_access(input bit we, input logic [1:0] size, input bit uns,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output bit e_err, output logic [31:0] e_rd, output int e_lat,
                                       output int e_nrd, output int e_nwr);
        int nb;
        bit ok;
        int base;
        logic [31:0] v;
        case (size)
            2'b00:   nb = 1;
            2'b01:   nb = 2;
            2'b10:   nb = 4;
            default: nb = 0;
        endcase
`ifndef LSU32_SUBWORD_EN
        if (nb != 4) nb = 0;
`endif
        ok = 1'b0;
        if (nb != 0 && addr < 32'd128) ok = ((int'(addr[1:0]) % nb) == 0);
        e_rd = '0; e_nrd = 0; e_nwr = 0; e_err = 1'b1; e_lat = 1;
        if (!ok) return;
        e_err = 1'b0;
        base = int'(addr[6:0]);
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[base+i] = 8'(wdata >> (8*(nb-1-i)));
            e_nwr = 1;
            e_nrd = (nb == 4) ? 0 : 1;
            e_lat = (nb == 4) ? 2 : 3;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[base+i]);
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            e_rd = v; e_nrd = 1; e_lat = 2;
        end
    endfunction

    // Issues one request, then scrambles the inputs to prove they were latched; waits at most 8 cycles for ready.
    task automatic do_access(input bit we, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output bit got, output logic [31:0] rd, output bit er, output int lat,
                             output int nrd, output int nwr, output bit badaddr);
        got = 0; rd = '0; er = 0; lat = 0; nrd = 0; nwr = 0; badaddr = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = we; bus.size = size; bus.uns = uns; bus.addr = addr; bus.wdata = wdata;
        @(posedge clk);
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req = 1'b0; bus.we = 1'($urandom); bus.size = 2'($urandom);
                bus.uns = 1'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
            end
            if (bus.mem_read)  nrd++;
            if (bus.mem_write) nwr++;
            if ((bus.mem_read || bus.mem_write) && bus.mem_address !== {addr[31:2], 2'b00}) badaddr = 1;
            if (bus.ready) begin got = 1; lat = k; rd = bus.rdata; er = bus.err; end
        end
        @(posedge clk);
        $display("txn %s size=%0d uns=%0d addr=%08h wdata=%08h -> ready@%0d rdata=%08h err=%0d",
                 we ? "st" : "ld", size, uns, addr, wdata, lat, rd, er);
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({bus.busy, bus.ready, bus.err, bus.mem_read, bus.mem_write} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %05b expected 00000",
                     {bus.busy, bus.ready, bus.err, bus.mem_read, bus.mem_write});
        end
        n_cmp++;
        if ({bus.rdata, bus.mem_address, bus.mem_wdata} !== 96'd0) begin
            n_bad++;
            $display("FAIL reset_data: got rdata=%08h addr=%08h wdata=%08h expected all 0",
                     bus.rdata, bus.mem_address, bus.mem_wdata);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy: got %0b expected 0", bus.busy);
        end
    endtask

    task automatic test_abort();
        int nr, nw;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.uns = 1'b0;
        bus.addr = 32'h10; bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        n_cmp++;
        if (bus.mem_write !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_write_phase: mem_write got %0b expected 1", bus.mem_write);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.ready, bus.mem_read, bus.mem_write} !== 4'b0) begin
            n_bad++;
            $display("FAIL abort_async: busy/ready/rd/wr got %04b expected 0000",
                     {bus.busy, bus.ready, bus.mem_read, bus.mem_write});
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        nr = 0; nw = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.ready) nr++;
            if (bus.mem_write) nw++;
        end
        $display("txn st size=2 addr=00000010 wdata=deadbeef aborted by reset");
        n_cmp++;
        if (nr != 0 || nw != 0) begin
            n_bad++;
            $display("FAIL abort_no_pulse: ready=%0d write=%0d expected 0/0", nr, nw);
        end
        n_cmp++;
        if (dmem[4] !== 32'h8822_F344) begin
            n_bad++;
            $display("FAIL abort_word: got %08h expected 8822f344", dmem[4]);
        end
    endtask

    task automatic test_directed();
        dvec_t v [8];
        bit got, er, badaddr, e_err;
        logic [31:0] rd, e_rd;
        int lat, nrd, nwr, e_lat, e_nrd, e_nwr;
`ifdef LSU32_SUBWORD_EN
        v[0] = '{0, 2'b00, 0, 32'h10, 32'h0,  32'hFFFF_FF88, 0, 2, 0, 32'h0};
        v[1] = '{0, 2'b00, 1, 32'h10, 32'h0,  32'h0000_0088, 0, 2, 0, 32'h0};
        v[2] = '{0, 2'b01, 0, 32'h12, 32'h0,  32'hFFFF_F344, 0, 2, 0, 32'h0};
        v[3] = '{0, 2'b01, 1, 32'h12, 32'h0,  32'h0000_F344, 0, 2, 0, 32'h0};
        v[4] = '{1, 2'b00, 0, 32'h13, 32'hAB, 32'h0,         0, 3, 1, 32'h8822_F3AB};
        v[5] = '{0, 2'b10, 0, 32'h10, 32'h0,  32'h8822_F3AB, 0, 2, 1, 32'h8822_F3AB};
`else
        v[0] = '{0, 2'b00, 0, 32'h10, 32'h0,  32'h0,         1, 1, 0, 32'h0};
        v[1] = '{0, 2'b00, 1, 32'h10, 32'h0,  32'h0,         1, 1, 0, 32'h0};
        v[2] = '{0, 2'b01, 0, 32'h12, 32'h0,  32'h0,         1, 1, 0, 32'h0};
        v[3] = '{0, 2'b01, 1, 32'h12, 32'h0,  32'h0,         1, 1, 0, 32'h0};
        v[4] = '{1, 2'b00, 0, 32'h13, 32'hAB, 32'h0,         1, 1, 1, 32'h8822_F344};
        v[5] = '{0, 2'b10, 0, 32'h10, 32'h0,  32'h8822_F344, 0, 2, 1, 32'h8822_F344};
`endif
        v[6] = '{0, 2'b10, 0, 32'h12, 32'h0,  32'h0,         1, 1, 0, 32'h0};
        v[7] = '{0, 2'b10, 0, 32'h80, 32'h0,  32'h0,         1, 1, 0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            ref_access(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, e_err, e_rd, e_lat, e_nrd, e_nwr);
            do_access(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, got, rd, er, lat, nrd, nwr, badaddr);
            n_cmp++;
            if (!got || lat != v[i].lat) begin
                n_bad++;
                $display("FAIL dir_latency #%0d: got ready=%0b at %0d expected %0d", i, got, lat, v[i].lat);
            end
            n_cmp++;
            if (rd !== v[i].rd || er !== v[i].er) begin
                n_bad++;
                $display("FAIL dir_result #%0d: got rdata=%08h err=%0b expected %08h err=%0b",
                         i, rd, er, v[i].rd, v[i].er);
            end
            n_cmp++;
            if (nrd != e_nrd || nwr != e_nwr || badaddr) begin
                n_bad++;
                $display("FAIL dir_membus #%0d: got rd=%0d wr=%0d badaddr=%0b expected %0d/%0d/0",
                         i, nrd, nwr, badaddr, e_nrd, e_nwr);
            end
            if (v[i].ck) begin
                n_cmp++;
                if (dmem[v[i].addr[6:2]] !== v[i].word) begin
                    n_bad++;
                    $display("FAIL dir_word #%0d: got %08h expected %08h", i, dmem[v[i].addr[6:2]], v[i].word);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit e_err;
        logic [31:0] e_rd0, e_rd1;
        logic [31:0] got_rd [2];
        int e_lat, e_nrd, e_nwr, nready;
        logic [8:0] rmask;
        ref_access(0, 2'b10, 0, 32'h14, 32'h0, e_err, e_rd0, e_lat, e_nrd, e_nwr);
        ref_access(0, 2'b10, 0, 32'h18, 32'h0, e_err, e_rd1, e_lat, e_nrd, e_nwr);
        got_rd[0] = '0; got_rd[1] = '0;
        rmask = '0; nready = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.uns = 1'b0; bus.addr = 32'h14; bus.wdata = '0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.ready) begin
                rmask[k] = 1'b1;
                if (nready < 2) got_rd[nready] = bus.rdata;
                nready++;
                if (nready == 1) bus.addr = 32'h18;
                else bus.req = 1'b0;
            end
            if (k < 8) @(posedge clk);
        end
        bus.req = 1'b0;
        @(posedge clk);
        $display("txn ld back-to-back 00000014/00000018 -> ready mask %09b rdata %08h %08h",
                 rmask, got_rd[0], got_rd[1]);
        n_cmp++;
        if (rmask !== 9'b0_0010_0100) begin
            n_bad++;
            $display("FAIL b2b_timing: ready mask %09b expected 000100100", rmask);
        end
        n_cmp++;
        if (got_rd[0] !== e_rd0 || got_rd[1] !== e_rd1) begin
            n_bad++;
            $display("FAIL b2b_data: got %08h %08h expected %08h %08h", got_rd[0], got_rd[1], e_rd0, e_rd1);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            bit we, uns, got, er, badaddr, e_err;
            logic [1:0] sz;
            logic [31:0] a, wd, rd, e_rd;
            int pick, lat, nrd, nwr, e_lat, e_nrd, e_nwr;
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            wd = $urandom;
            pick = $urandom_range(0, 9);
            if (pick == 0) a = $urandom | 32'h0000_0080;
            else a = 32'($urandom_range(0, 127));
            if (pick >= 6) begin sz = 2'b10; a = {a[31:2], 2'b00}; end
            ref_access(we, sz, uns, a, wd, e_err, e_rd, e_lat, e_nrd, e_nwr);
            do_access(we, sz, uns, a, wd, got, rd, er, lat, nrd, nwr, badaddr);
            n_cmp++;
            if (!got || lat != e_lat || er !== e_err) begin
                n_bad++;
                $display("FAIL rand_timing #%0d: got ready=%0b at %0d err=%0b expected %0d err=%0b",
                         t, got, lat, er, e_lat, e_err);
            end
            n_cmp++;
            if (rd !== e_rd) begin
                n_bad++;
                $display("FAIL rand_rdata #%0d: got %08h expected %08h", t, rd, e_rd);
            end
            n_cmp++;
            if (nrd != e_nrd || nwr != e_nwr || badaddr) begin
                n_bad++;
                $display("FAIL rand_membus #%0d: got rd=%0d wr=%0d badaddr=%0b expected %0d/%0d/0",
                         t, nrd, nwr, badaddr, e_nrd, e_nwr);
            end
            n_cmp++;
            if (dmem[a[6:2]] !== ref_word(int'(a[6:2]))) begin
                n_bad++;
                $display("FAIL rand_word #%0d: got %08h expected %08h", t, dmem[a[6:2]], ref_word(int'(a[6:2])));
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        preload = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.uns = 1'b0; bus.addr = '0; bus.wdata = '0;
        for (int i = 0; i < 32; i++) begin
            w = (i == 4) ? 32'h8822_F344 : $urandom;
            pre[i] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = 8'(w >> (8*(3-b)));
        end
        test_reset();
        test_abort();
        test_directed();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
